alu_result_stage: RTL and testbench

- Pipeline stage directly downstream of the 5-bit ALU functional units (rotate, shift, logic).
- Captures each unit's result and flags (z, cf, sf, zf) with a destination register index into an in-order FIFO, under valid/ready handshakes on both sides.
- Maintains the architectural flag register (CF, SF, ZF) and a retired-result counter.
- Decouples combinational ALU output timing from register-file writeback.

---
 rtl/alu_result_stage_if.sv | 28 ++
 rtl/alu_result_stage.sv | 65 ++++++
 tb/tb_alu_result_stage.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU functional units, this result stage and writeback.
interface alu_result_stage_if #(
    parameter int WIDTH = 5,
    parameter int RD_W  = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_z;
    logic             in_cf;
    logic             in_sf;
    logic             in_zf;
    logic [RD_W-1:0]  in_rd;
    logic             in_flag_we;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_z;
    logic [RD_W-1:0]  out_rd;

    modport master (
        output in_valid, in_z, in_cf, in_sf, in_zf, in_rd, in_flag_we, out_ready,
        input  in_ready, out_valid, out_z, out_rd
    );

    modport slave (
        input  in_valid, in_z, in_cf, in_sf, in_zf, in_rd, in_flag_we, out_ready,
        output in_ready, out_valid, out_z, out_rd
    );
endinterface

// File: rtl/alu_result_stage.sv
// In-order result FIFO between the ALU units and writeback, plus the
// architectural flag register and a retired-result counter.
module alu_result_stage #(
    parameter int WIDTH = 5,
    parameter int RD_W  = 3,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_result_stage_if.slave   bus,
    input  logic                flags_clr,
    output logic [2:0]          flags,
    output logic [7:0]          retired
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_z  [DEPTH];
    logic [RD_W-1:0]  mem_rd [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      count;
    logic             push, pop;

    // in_ready depends only on occupancy, never on out_ready.
    assign bus.in_ready  = (count < (AW+1)'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign bus.out_z     = bus.out_valid ? mem_z[rptr]  : '0;
    assign bus.out_rd    = bus.out_valid ? mem_rd[rptr] : '0;

    assign push = bus.in_valid  && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_z[wptr]  <= bus.in_z;
            mem_rd[wptr] <= bus.in_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            retired <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) begin
                rptr    <= rptr + 1'b1;
                retired <= retired + 8'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Flags track issue order, so they update on accepted push, not on pop.
    always_ff @(posedge clk) begin
        if (rst)                         flags <= 3'b000;
        else if (flags_clr)              flags <= 3'b000;
        else if (push && bus.in_flag_we) flags <= {bus.in_cf, bus.in_sf, bus.in_zf};
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;
    logic       clk = 1'b0;
    logic       rst;
    logic       flags_clr;
    logic [2:0] flags;
    logic [7:0] retired;
    int         checks = 0;
    int         errors = 0;

    alu_result_stage_if #(.WIDTH(5), .RD_W(3)) bus ();

    alu_result_stage #(.WIDTH(5), .RD_W(3), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .flags_clr (flags_clr),
        .flags     (flags),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic [4:0] z, input logic [2:0] rd, input logic we,
                            input logic [2:0] f);
        bus.in_valid   = 1'b1;
        bus.in_z       = z;
        bus.in_rd      = rd;
        bus.in_flag_we = we;
        {bus.in_cf, bus.in_sf, bus.in_zf} = f;
    endtask

    initial begin
        rst = 1'b1; flags_clr = 1'b0;
        bus.in_valid = 1'b0; bus.in_z = '0; bus.in_rd = '0; bus.in_flag_we = 1'b0;
        bus.in_cf = 1'b0; bus.in_sf = 1'b0; bus.in_zf = 1'b0; bus.out_ready = 1'b0;
        #2;
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_z",     32'(bus.out_z), 0);
        chk("rst_out_rd",    32'(bus.out_rd), 0);
        chk("rst_in_ready",  32'(bus.in_ready), 1);
        chk("rst_flags",     32'(flags), 0);
        chk("rst_retired",   32'(retired), 0);

        // single push then pop
        set_push(5'b10110, 3'd3, 1'b1, 3'b010);
        tick();
        bus.in_valid = 1'b0;
        chk("single_valid", 32'(bus.out_valid), 1);
        chk("single_z",     32'(bus.out_z), 32'h16);
        chk("single_rd",    32'(bus.out_rd), 3);
        chk("single_flags", 32'(flags), 32'b010);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("pop_valid",   32'(bus.out_valid), 0);
        chk("pop_z",       32'(bus.out_z), 0);
        chk("pop_retired", 32'(retired), 1);

        // empty pop is ignored
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("empty_pop_retired", 32'(retired), 1);

        // fill to full
        for (int i = 1; i <= 4; i++) begin
            set_push(5'(i), 3'(i), 1'b0, 3'b000);
            tick();
        end
        chk("full_in_ready", 32'(bus.in_ready), 0);
        set_push(5'd9, 3'd7, 1'b1, 3'b111);
        tick();
        bus.in_valid = 1'b0;
        chk("full_flags_hold", 32'(flags), 32'b010);
        chk("full_still_full", 32'(bus.in_ready), 0);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain_z%0d", i),  32'(bus.out_z), 32'(i));
            chk($sformatf("drain_rd%0d", i), 32'(bus.out_rd), 32'(i));
            bus.out_ready = 1'b1;
            tick();
        end
        bus.out_ready = 1'b0;
        chk("drain_empty",   32'(bus.out_valid), 0);
        chk("drain_retired", 32'(retired), 5);

        // simultaneous push and pop at count 2
        set_push(5'd10, 3'd1, 1'b0, 3'b000); tick();
        set_push(5'd11, 3'd2, 1'b0, 3'b000); tick();
        for (int k = 0; k < 3; k++) begin
            set_push(5'(12 + k), 3'(3 + k), 1'b0, 3'b000);
            bus.out_ready = 1'b1;
            chk($sformatf("pp_head%0d", k), 32'(bus.out_z), 32'(10 + k));
            tick();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        chk("pp_retired", 32'(retired), 8);
        chk("pp_head",    32'(bus.out_z), 13);
        bus.out_ready = 1'b1;
        tick();
        chk("pp_second", 32'(bus.out_z), 14);
        tick();
        bus.out_ready = 1'b0;
        chk("pp_count2_empty", 32'(bus.out_valid), 0);

        // flag priority
        set_push(5'd1, 3'd1, 1'b1, 3'b111);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        chk("clr_over_we", 32'(flags), 0);
        set_push(5'd2, 3'd2, 1'b0, 3'b111);
        tick();
        chk("we0_hold", 32'(flags), 0);
        set_push(5'd3, 3'd3, 1'b1, 3'b101);
        tick();
        bus.in_valid = 1'b0;
        chk("we1_load", 32'(flags), 32'b101);

        // reset mid-operation (count=3)
        set_push(5'd4, 3'd4, 1'b1, 3'b111);
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        chk("mid_rst_valid",   32'(bus.out_valid), 0);
        chk("mid_rst_flags",   32'(flags), 0);
        chk("mid_rst_retired", 32'(retired), 0);
        chk("mid_rst_ready",   32'(bus.in_ready), 1);
        chk("mid_rst_z",       32'(bus.out_z), 0);

        // retired counter wrap
        for (int n = 1; n <= 257; n++) begin
            set_push(5'(n), 3'(n), 1'b0, 3'b000);
            tick();
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            if (n == 255) chk("wrap_255", 32'(retired), 255);
            if (n == 256) chk("wrap_0",   32'(retired), 0);
        end
        chk("wrap_1",     32'(retired), 1);
        chk("wrap_empty", 32'(bus.out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
